user_uart_tx: RTL and testbench

- 8N1 UART transmitter inside the user project area. Drives a serial line on an mprj_io pad so the management-side UART monitor can receive status bytes.
- Bytes arrive over a valid/ready stream and are buffered in a small FIFO.
- The bit period is programmable through a divider register, which is written from Wishbone/LA logic upstream.

---
 rtl/user_uart_pkg.sv | 19 +
 rtl/user_uart_fifo.sv | 69 ++++++
 rtl/user_uart_tx.sv | 147 ++++++++++++++
 tb/tb_user_uart_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_uart_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the user-area 8N1 UART transmitter.
package user_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int MIN_DIV    = 2;

  // Wide enough to index every bit of a frame, so data indexing never saturates.
  localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/user_uart_fifo.sv
`timescale 1ns/1ps
// Small synchronous FIFO with registered full/empty flags and occupancy level.
module user_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Flags are computed from the next level so they come straight off flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/user_uart_tx.sv
`timescale 1ns/1ps
// 8N1 UART transmitter: byte FIFO, programmable bit period, flop-driven tx pad.
//
// state | meaning
// IDLE  | line high, waiting for cfg_en and a queued byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  uart_state_t          state;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     period;
  logic [DIV_W-1:0]     div_eff;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 pop_go;
  logic                 bit_end;

  user_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  assign div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
  assign bit_end = (cnt == period - DIV_W'(1));
  assign pop_go  = cfg_en && !fifo_empty;

  // Pop only on the cycle the FSM commits to a new START.
  assign fifo_pop = pop_go && ((state == IDLE) || ((state == STOP) && bit_end));

  assign busy = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= DIV_W'(MIN_DIV);
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (fifo_pop) begin
            shift   <= fifo_rd_data;
            period  <= div_eff;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            // Chaining here avoids an idle cycle between consecutive frames.
            if (fifo_pop) begin
              shift   <= fifo_rd_data;
              period  <= div_eff;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_uart_tx.sv
`timescale 1ns/1ps
// Directed bench for user_uart_tx: frame shape, chaining, gating, divider and reset.
module tb_user_uart_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_div = 16'd4;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  user_uart_tx #(
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .LVL_W      (3)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples one frame starting at the current (first start-bit) sample.
  task automatic capture_frame(input int p, output logic [9:0] bits, output int glitches);
    logic first;
    bits = '0;
    glitches = 0;
    first = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < p; c++) begin
        if (c == 0) begin
          first = tx;
          bits[b] = tx;
        end else if (tx !== first) begin
          glitches++;
        end
        step();
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    resetn = 1'b1;
    repeat (3) step();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
  endtask

  task automatic test_single_byte();
    logic [9:0] bits;
    int gl;
    cfg_div = 16'd4;
    cfg_en = 1'b1;
    in_data = 8'hA5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_pre_start_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_queued: got %b want 1", busy); end
    step();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL single_latency_tx: got %b want 0", tx); end
    capture_frame(4, bits, gl);
    n_cmp++; if (bits !== 10'b1101001010) begin n_err++; $display("FAIL single_frame: got %b want %b", bits, 10'b1101001010); end
    n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL single_bit_width: got %0d glitches want 0", gl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL single_level_end: got %0d want 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5];
    logic [9:0] bits;
    int gl;
    vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    cfg_en = 1'b0;
    cfg_div = 16'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      step();
    end
    in_data = vals[4];
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL b2b_level_full: got %0d want 4", fifo_level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); end
    step();
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL b2b_full_hold: got %0d want 4", fifo_level); end
    cfg_en = 1'b1;
    fork
      begin
        step();
        n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL b2b_first_start: got %b want 0", tx); end
        for (int f = 0; f < 5; f++) begin
          capture_frame(3, bits, gl);
          n_cmp++; if (bits !== frame_of(vals[f])) begin n_err++; $display("FAIL b2b_frame%0d: got %b want %b", f, bits, frame_of(vals[f])); end
          n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL b2b_width%0d: got %0d glitches want 0", f, gl); end
        end
      end
      begin
        step();
        n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL b2b_level_after_pop: got %0d want 3", fifo_level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready); end
        step();
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL b2b_fifth_accept: got %0d want 4", fifo_level); end
        in_valid = 1'b0;
      end
    join
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL b2b_tx_end: got %b want 1", tx); end
  endtask

  task automatic test_enable_gating();
    logic [9:0] bits;
    int gl;
    cfg_div = 16'd3;
    cfg_en = 1'b1;
    in_data = 8'h55;
    in_valid = 1'b1;
    step();
    in_data = 8'h66;
    step();
    in_valid = 1'b0;
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL gate_start55: got %b want 0", tx); end
    fork
      capture_frame(3, bits, gl);
      begin
        repeat (12) step();
        cfg_en = 1'b0;
      end
    join
    n_cmp++; if (bits !== frame_of(8'h55)) begin n_err++; $display("FAIL gate_frame55: got %b want %b", bits, frame_of(8'h55)); end
    n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL gate_width55: got %0d glitches want 0", gl); end
    repeat (6) step();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL gate_hold_tx: got %b want 1", tx); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL gate_hold_level: got %0d want 1", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL gate_hold_busy: got %b want 1", busy); end
    cfg_en = 1'b1;
    step();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL gate_restart_tx: got %b want 0", tx); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL gate_restart_level: got %0d want 0", fifo_level); end
    capture_frame(3, bits, gl);
    n_cmp++; if (bits !== frame_of(8'h66)) begin n_err++; $display("FAIL gate_frame66: got %b want %b", bits, frame_of(8'h66)); end
    n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL gate_width66: got %0d glitches want 0", gl); end
  endtask

  task automatic test_div_clamp();
    logic [9:0] bits;
    int gl;
    cfg_en = 1'b1;
    cfg_div = 16'd0;
    in_data = 8'h3C;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL clamp0_start: got %b want 0", tx); end
    capture_frame(2, bits, gl);
    n_cmp++; if (bits !== frame_of(8'h3C)) begin n_err++; $display("FAIL clamp0_frame: got %b want %b", bits, frame_of(8'h3C)); end
    n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL clamp0_width: got %0d glitches want 0", gl); end
    cfg_div = 16'd1;
    in_data = 8'hE1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    capture_frame(2, bits, gl);
    n_cmp++; if (bits !== frame_of(8'hE1)) begin n_err++; $display("FAIL clamp1_frame: got %b want %b", bits, frame_of(8'hE1)); end
    n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL clamp1_width: got %0d glitches want 0", gl); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL clamp_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_div_shadow();
    logic [9:0] bits_a;
    logic [9:0] bits_b;
    int gl_a;
    int gl_b;
    cfg_en = 1'b1;
    cfg_div = 16'd5;
    in_data = 8'hC3;
    in_valid = 1'b1;
    step();
    in_data = 8'h96;
    step();
    in_valid = 1'b0;
    fork
      begin
        capture_frame(5, bits_a, gl_a);
        capture_frame(8, bits_b, gl_b);
      end
      begin
        repeat (20) step();
        cfg_div = 16'd8;
      end
    join
    n_cmp++; if (bits_a !== frame_of(8'hC3)) begin n_err++; $display("FAIL shadow_frame5: got %b want %b", bits_a, frame_of(8'hC3)); end
    n_cmp++; if (gl_a !== 0) begin n_err++; $display("FAIL shadow_width5: got %0d glitches want 0", gl_a); end
    n_cmp++; if (bits_b !== frame_of(8'h96)) begin n_err++; $display("FAIL shadow_frame8: got %b want %b", bits_b, frame_of(8'h96)); end
    n_cmp++; if (gl_b !== 0) begin n_err++; $display("FAIL shadow_width8: got %0d glitches want 0", gl_b); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL shadow_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    cfg_en = 1'b1;
    cfg_div = 16'd4;
    in_data = 8'hF0;
    in_valid = 1'b1;
    step();
    in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rstmid_start: got %b want 0", tx); end
    repeat (10) step();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rstmid_data_low: got %b want 0", tx); end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    step();
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL rstmid_residual: got %0d low samples want 0", lows); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_full_ignore();
    logic [7:0] vals [6];
    logic [9:0] bits;
    int gl;
    int lows;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cfg_en = 1'b0;
    cfg_div = 16'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = vals[i];
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL full_disabled_tx: got %b want 1", tx); end
    cfg_en = 1'b1;
    step();
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL full_first_start: got %b want 0", tx); end
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL full_level_pop: got %0d want 3", fifo_level); end
    for (int f = 0; f < 4; f++) begin
      capture_frame(2, bits, gl);
      n_cmp++; if (bits !== frame_of(vals[f])) begin n_err++; $display("FAIL full_frame%0d: got %b want %b", f, bits, frame_of(vals[f])); end
      n_cmp++; if (gl !== 0) begin n_err++; $display("FAIL full_width%0d: got %0d glitches want 0", f, gl); end
    end
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1) lows++;
      step();
    end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL full_extra_frame: got %0d low samples want 0", lows); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_gating();
    test_div_clamp();
    test_div_shadow();
    test_reset_mid_frame();
    test_full_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
